// File: rtl/reg_bus_bridge.sv
// rtl/reg_bus_bridge.sv - single-outstanding host-to-register-strobe bridge with address decode
module reg_bus_bridge #(
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned NUM_REGS = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_wr,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [REG_WIDTH-1:0]          req_wdata,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [REG_WIDTH-1:0]          resp_rdata,
  output logic                          resp_err,
  output logic [NUM_REGS-1:0]           reg_wr_sel,
  output logic                          reg_wr_rd,
  output logic [REG_WIDTH-1:0]          reg_wr_data,
  input  logic [NUM_REGS*REG_WIDTH-1:0] reg_rd_bus
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t                state_q;
  state_t                state_d;
  logic [IDX_W-1:0]      idx_q;
  logic [1:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] off;
  logic                  borrow;
  logic                  dec_err;
  logic [IDX_W-1:0]      dec_idx;
  logic [NUM_REGS-1:0]   dec_sel;
  logic [REG_WIDTH-1:0]  rd_word;
  logic                  accept;
  logic                  sample_rd;

  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = (state_q == RESP);
  assign accept     = req_valid && req_ready;
  assign sample_rd  = ((state_q == ACCESS) && !reg_wr_rd && (RD_LAT == 0)) ||
                      ((state_q == WAIT) && (cnt_q == 2'd1));

  // Decode the host byte address; the borrow bit flags addresses below the window
  always_comb begin
    {borrow, off} = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    dec_idx = off[2 +: IDX_W];
    dec_err = borrow || (off[1:0] != 2'b00) || ((off >> 2) >= ADDR_WIDTH'(NUM_REGS));
    dec_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      dec_sel[i] = (dec_idx == IDX_W'(i));
    end
  end

  // Pick the selected register's read word out of the concatenated bus
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        rd_word = reg_rd_bus[i*REG_WIDTH +: REG_WIDTH];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = dec_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        state_d = (!reg_wr_rd && (RD_LAT != 0)) ? WAIT : RESP;
      end
      WAIT: begin
        if (cnt_q == 2'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Strobe outputs, latched request fields, wait counter and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      cnt_q       <= '0;
      reg_wr_sel  <= '0;
      reg_wr_rd   <= 1'b0;
      reg_wr_data <= '0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
    end else begin
      // The select is a single-cycle pulse covering only the ACCESS cycle
      reg_wr_sel <= '0;
      if (accept && !dec_err) begin
        idx_q       <= dec_idx;
        reg_wr_sel  <= dec_sel;
        reg_wr_rd   <= req_wr;
        reg_wr_data <= req_wdata;
      end
      if (accept && dec_err) begin
        resp_err   <= 1'b1;
        resp_rdata <= '0;
      end
      if (state_q == ACCESS) begin
        cnt_q      <= 2'(RD_LAT);
        resp_err   <= 1'b0;
        resp_rdata <= '0;
      end
      if (state_q == WAIT) begin
        cnt_q <= cnt_q - 2'd1;
      end
      if (sample_rd) begin
        resp_rdata <= rd_word;
      end
      if (resp_valid && resp_ready) begin
        resp_err   <= 1'b0;
        resp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_reg_bus_bridge.sv
// tb/tb_reg_bus_bridge.sv - randomized self-checking bench for reg_bus_bridge
module tb_reg_bus_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         req_valid, req_wr, resp_ready;
  logic [11:0]  req_addr;
  logic [31:0]  req_wdata;
  logic [255:0] rd_bus;
  int           cur;

  logic        req_valid_a, req_valid_b;
  logic        req_ready_a, req_ready_b, resp_valid_a, resp_valid_b;
  logic        resp_err_a, resp_err_b, wr_rd_a, wr_rd_b;
  logic [31:0] resp_rdata_a, resp_rdata_b, wr_data_a, wr_data_b;
  logic [7:0]  sel_a, sel_b;

  logic        o_req_ready, o_resp_valid, o_resp_err, o_wr_rd;
  logic [31:0] o_resp_rdata, o_wr_data;
  logic [7:0]  o_sel;

  int base_of [2] = '{0, 256};
  int lat_of  [2] = '{1, 0};
  int checks = 0;
  int failures = 0;

  assign req_valid_a  = req_valid && (cur == 0);
  assign req_valid_b  = req_valid && (cur == 1);
  assign o_req_ready  = (cur == 1) ? req_ready_b  : req_ready_a;
  assign o_resp_valid = (cur == 1) ? resp_valid_b : resp_valid_a;
  assign o_resp_err   = (cur == 1) ? resp_err_b   : resp_err_a;
  assign o_wr_rd      = (cur == 1) ? wr_rd_b      : wr_rd_a;
  assign o_resp_rdata = (cur == 1) ? resp_rdata_b : resp_rdata_a;
  assign o_wr_data    = (cur == 1) ? wr_data_b    : wr_data_a;
  assign o_sel        = (cur == 1) ? sel_b        : sel_a;

  reg_bus_bridge #(
    .REG_WIDTH(32), .ADDR_WIDTH(12), .NUM_REGS(8), .BASE_ADDR(12'h000), .RD_LAT(1)
  ) u_dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_a), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata_a), .resp_err(resp_err_a),
    .reg_wr_sel(sel_a), .reg_wr_rd(wr_rd_a), .reg_wr_data(wr_data_a),
    .reg_rd_bus(rd_bus)
  );

  reg_bus_bridge #(
    .REG_WIDTH(32), .ADDR_WIDTH(12), .NUM_REGS(8), .BASE_ADDR(12'h100), .RD_LAT(0)
  ) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata_b), .resp_err(resp_err_b),
    .reg_wr_sel(sel_b), .reg_wr_rd(wr_rd_b), .reg_wr_data(wr_data_b),
    .reg_rd_bus(rd_bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (dut %0d, t=%0t)", tag, got, exp, cur, $time);
    end
  endtask

  function automatic logic [255:0] rand_bus();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [11:0] rand_addr(input int d);
    int b;
    b = base_of[d];
    case ($urandom_range(0, 5))
      0, 1, 2: return 12'(b + 4 * $urandom_range(0, 7));
      3:       return 12'(b + 4 * $urandom_range(0, 7) + $urandom_range(1, 3));
      4:       return 12'(b + 32 + 4 * $urandom_range(0, 20));
      default: return 12'($urandom);
    endcase
  endfunction

  // Called at a negedge with the chosen bridge idle; returns at the negedge where it is idle again
  task automatic run_txn(input int d, input bit wr, input logic [11:0] addr,
                         input logic [31:0] wdata, input int stall, input bit hold_valid);
    int a, b, idx, lat, rdl, last;
    bit err;
    logic [7:0]  exp_sel;
    logic [31:0] exp_rd;
    cur = d;
    #1;
    a = int'(addr);
    b = base_of[d];
    rdl = lat_of[d];
    err = (a < b) || (((a - b) % 4) != 0) || (((a - b) / 4) >= 8);
    idx = err ? 0 : (a - b) / 4;
    lat = err ? 1 : (wr ? 2 : 2 + rdl);
    exp_sel = err ? 8'h00 : 8'(1 << idx);
    last = lat + stall + 1;
    exp_rd = '0;
    check("req_ready_start", o_req_ready, 1'b1);
    req_valid = 1'b1;
    req_wr = wr;
    req_addr = addr;
    req_wdata = wdata;
    resp_ready = (stall == 0);
    rd_bus = rand_bus();
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      rd_bus = rand_bus();
      if (!err && !wr && (k == 1 + rdl)) exp_rd = rd_bus[idx*32 +: 32];
      if (k == 1) begin
        if (hold_valid) begin
          req_wr = 1'($urandom);
          req_addr = 12'($urandom);
          req_wdata = $urandom;
        end else begin
          req_valid = 1'b0;
        end
      end
      check("reg_wr_sel", o_sel, (k == 1) ? exp_sel : 8'h00);
      if (!err && k == 1) check("reg_wr_rd", o_wr_rd, wr);
      if (!err) check("reg_wr_data", o_wr_data, wdata);
      check("resp_valid", o_resp_valid, (k >= lat) && (k < last));
      if (k >= lat && k < last) begin
        check("resp_err", o_resp_err, err);
        check("resp_rdata", o_resp_rdata, exp_rd);
      end
      check("req_ready", o_req_ready, k == last);
      if (k == last - 1) resp_ready = 1'b1;
      if (k == last) req_valid = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, o_req_ready, 1'b0);
    check({tag, "_resp_valid"}, o_resp_valid, 1'b0);
    check({tag, "_resp_err"}, o_resp_err, 1'b0);
    check({tag, "_resp_rdata"}, o_resp_rdata, 32'h0);
    check({tag, "_sel"}, o_sel, 8'h00);
    check({tag, "_wr_rd"}, o_wr_rd, 1'b0);
    check({tag, "_wr_data"}, o_wr_data, 32'h0);
  endtask

  initial begin
    int d;
    rst = 1'b1;
    req_valid = 1'b0;
    req_wr = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    resp_ready = 1'b0;
    rd_bus = '0;
    cur = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      cur = i;
      #1;
      check_all_zero("reset");
    end
    rst = 1'b0;

    // Directed: write path, read paths at both latencies, decode errors
    run_txn(0, 1'b1, 12'h008, 32'hA5A5_0001, 0, 1'b0);
    run_txn(0, 1'b0, 12'h008, 32'h0, 0, 1'b0);
    run_txn(1, 1'b0, 12'h108, 32'h0, 0, 1'b0);
    run_txn(0, 1'b0, 12'h006, 32'h0, 0, 1'b0);
    run_txn(0, 1'b0, 12'h020, 32'h0, 0, 1'b0);
    run_txn(1, 1'b0, 12'h0FC, 32'h0, 0, 1'b0);

    // Backpressure: response held five cycles while a second request waits
    run_txn(0, 1'b0, 12'h00C, 32'h1234_5678, 5, 1'b1);

    // Reset while the read is waiting on register latency
    cur = 0;
    #1;
    req_valid = 1'b1;
    req_wr = 1'b0;
    req_addr = 12'h008;
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("postreset_resp_valid", o_resp_valid, 1'b0);
      check("postreset_sel", o_sel, 8'h00);
    end
    run_txn(0, 1'b1, 12'h01C, 32'hCAFE_F00D, 0, 1'b0);

    // Back-to-back writes with request valid and response ready held high
    for (int i = 0; i < 4; i++) begin
      run_txn(0, 1'b1, 12'(4 * i), $urandom, 0, 1'b1);
    end

    // Randomized traffic on both bridges
    for (int n = 0; n < 80; n++) begin
      d = int'($urandom_range(0, 1));
      run_txn(d, 1'($urandom), rand_addr(d), $urandom,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
              1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
